// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state type, matrix constants and key-code helpers for keypad_emulator
package keypad_pkg;

  typedef enum logic [2:0] {IDLE, BNC_IN, HOLD, BNC_OUT, GAP} kp_state_t;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam logic [KP_ROWS-1:0] KP_IDLE_ROWS = 4'b1111;

  function automatic logic [1:0] kp_row(input logic [3:0] code);
    return code[3:2];
  endfunction

  function automatic logic [1:0] kp_col(input logic [3:0] code);
    return code[1:0];
  endfunction

  function automatic int kp_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Fibonacci LFSR (taps 16,14,13,11), shifts right, advances when en is high
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic fb;

  assign fb = q[0] ^ q[2] ^ q[3] ^ q[5];

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= seed;
    end else if (en) begin
      q <= {fb, q[15:1]};
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - emulated 4x4 keypad answering column strobes on the rows for one timed key press
// KEYPAD_BOUNCE_EN: when defined, bounce phases drive the contact from an LFSR instead of a clean edge.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int          HOLD_CYCLES   = 2_700_000,
  parameter int          BOUNCE_CYCLES = 135_000,
  parameter int          GAP_CYCLES    = 270_000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KP_COLS-1:0] col,
  output logic [KP_ROWS-1:0] fil,
  input  logic [3:0]         key_code,
  input  logic               press_valid,
  output logic               press_ready,
  output logic               busy,
  output logic               contact
);

  localparam int MAX_CYCLES = kp_max3(HOLD_CYCLES, BOUNCE_CYCLES, GAP_CYCLES);
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] BNC_LOAD  = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  kp_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       code, code_nxt;
  logic             contact_nxt;
  logic             bnc_in_bit, bnc_out_bit;

`ifdef KEYPAD_BOUNCE_EN
  logic [15:0] lfsr_q;
  logic        lfsr_en;
  logic        lfsr_next0;
  logic        unused_lfsr;

  assign lfsr_en = (state == BNC_IN) || (state == BNC_OUT);

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (lfsr_en),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  // Register the bit the LFSR will hold next cycle so contact always equals LFSR[0] in a bounce phase.
  assign lfsr_next0  = lfsr_en ? lfsr_q[1] : lfsr_q[0];
  assign bnc_in_bit  = lfsr_next0;
  assign bnc_out_bit = lfsr_next0;
  assign unused_lfsr = ^lfsr_q[15:2];
`else
  logic unused_seed;

  assign bnc_in_bit  = 1'b1;
  assign bnc_out_bit = 1'b0;
  assign unused_seed = ^LFSR_SEED;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      code    <= '0;
      contact <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      code    <= code_nxt;
      contact <= contact_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    code_nxt    = code;
    contact_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (press_valid) begin
          state_nxt = BNC_IN;
          cnt_nxt   = BNC_LOAD;
          code_nxt  = key_code;
        end
      end
      BNC_IN, HOLD, BNC_OUT, GAP: begin
        if (cnt == '0) begin
          case (state)
            BNC_IN:  begin state_nxt = HOLD;    cnt_nxt = HOLD_LOAD; end
            HOLD:    begin state_nxt = BNC_OUT; cnt_nxt = BNC_LOAD;  end
            BNC_OUT: begin state_nxt = GAP;     cnt_nxt = GAP_LOAD;  end
            default: begin state_nxt = IDLE;    cnt_nxt = '0;        end
          endcase
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    case (state_nxt)
      BNC_IN:  contact_nxt = bnc_in_bit;
      HOLD:    contact_nxt = 1'b1;
      BNC_OUT: contact_nxt = bnc_out_bit;
      default: contact_nxt = 1'b0;
    endcase
  end

  // Passive matrix: a closed contact ties its row to its column with no clock in the path.
  always_comb begin
    fil = KP_IDLE_ROWS;
    if (contact && !col[kp_col(code)]) begin
      fil[kp_row(code)] = 1'b0;
    end
  end

  assign press_ready = (state == IDLE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - self-checking bench for keypad_emulator with a timeline model of each press
module tb_keypad_emulator;

  localparam int HOLD = 20;
  localparam int BNC  = 4;
  localparam int GAP  = 6;
  localparam int TOT  = BNC + HOLD + BNC + GAP;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef KEYPAD_BOUNCE_EN
  localparam bit BOUNCE_EN = 1'b1;
`else
  localparam bit BOUNCE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] col = 4'hF;
  logic [3:0] key_code = 4'h0;
  logic       press_valid = 1'b0;
  logic [3:0] fil;
  logic       press_ready, busy, contact;

  int n_checks = 0;
  int n_fail   = 0;
  int xfer_q[$];

  always #5 clk = ~clk;

  keypad_emulator #(
    .HOLD_CYCLES   (HOLD),
    .BOUNCE_CYCLES (BNC),
    .GAP_CYCLES    (GAP),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .col         (col),
    .fil         (fil),
    .key_code    (key_code),
    .press_valid (press_valid),
    .press_ready (press_ready),
    .busy        (busy),
    .contact     (contact)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  // 0 bounce-in, 1 hold, 2 bounce-out, 3 gap, by cycles elapsed since the press started
  function automatic int phase_of(input int e);
    if (e < BNC) return 0;
    if (e < BNC + HOLD) return 1;
    if (e < 2 * BNC + HOLD) return 2;
    return 3;
  endfunction

  int          cyc = 0;
  bit          m_known = 1'b0;
  bit          m_active = 1'b0;
  int          m_start = 0;
  logic [3:0]  m_code = 4'h0;
  logic [15:0] m_lfsr = SEED;

  always @(posedge clk) begin
    if (!rst) begin
      m_known  = 1'b1;
      m_active = 1'b0;
      m_lfsr   = SEED;
    end else if (m_known) begin
      if (m_active) begin
        if (phase_of(cyc - m_start) == 0 || phase_of(cyc - m_start) == 2) m_lfsr = lfsr_step(m_lfsr);
        if (cyc - m_start == TOT - 1) m_active = 1'b0;
      end else if (press_valid) begin
        m_active = 1'b1;
        m_start  = cyc + 1;
        m_code   = key_code;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic       ec;
    logic [3:0] ef;
    if (m_known) begin
      ec = 1'b0;
      if (m_active) begin
        case (phase_of(cyc - m_start))
          0:       ec = BOUNCE_EN ? m_lfsr[0] : 1'b1;
          1:       ec = 1'b1;
          2:       ec = BOUNCE_EN ? m_lfsr[0] : 1'b0;
          default: ec = 1'b0;
        endcase
      end
      ef = 4'hF;
      if (ec && !col[m_code[1:0]]) ef[m_code[3:2]] = 1'b0;
      check("model_contact", contact, ec);
      check("model_fil", fil, ef);
      check("model_press_ready", press_ready, !m_active);
      check("model_busy", busy, m_active);
      if (rst && press_valid && press_ready) xfer_q.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [3:0] k);
    key_code    = k;
    press_valid = 1'b1;
    tick();
    press_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      tick();
      @(negedge clk);
      n++;
    end
    check(name, busy, 1'b0);
    tick();
  endtask

  initial begin
    #200000;
    check("global_timeout", 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int         low, run, best, notf, tog, n0;
    logic       prev;
    logic [3:0] sweep [4];
    sweep = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // reset with a press request held
    rst = 1'b0; press_valid = 1'b1; key_code = 4'h6; col = 4'b1011;
    repeat (3) begin
      tick();
      @(negedge clk);
      check("t1_rst_fil", fil, 4'hF);
      check("t1_rst_ready", press_ready, 1'b1);
      check("t1_rst_busy", busy, 1'b0);
    end
    tick();
    rst = 1'b1; press_valid = 1'b0;
    tick();

    // key 6 (row 1, column 2) scanned on column 2
    press(4'h6);
    low = 0; run = 0; best = 0;
    for (int i = 0; i < TOT; i++) begin
      @(negedge clk);
      if (i == 0) check("t2_busy_after_xfer", busy, 1'b1);
      if (fil == 4'b1101) begin
        low++; run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
      tick();
    end
    check("t2_low_cycles", low, 24);
    check("t2_longest_run", best, BOUNCE_EN ? 20 : 24);
    @(negedge clk);
    check("t2_idle_after", busy, 1'b0);
    tick();

    // same key scanned on the wrong column
    col = 4'b1110;
    press(4'h6);
    notf = 0;
    for (int i = 0; i < TOT; i++) begin
      @(negedge clk);
      if (fil != 4'hF) notf++;
      tick();
    end
    check("t2_wrong_col", notf, 0);

    // key F with a rotating column scan
    press(4'hF);
    for (int i = 0; i < TOT; i++) begin
      col = (i == 10) ? 4'b0111 : (i == 11) ? 4'b1011 : sweep[i % 4];
      @(negedge clk);
      if (i == 10) check("t3_hit", fil, 4'b0111);
      if (i == 11) check("t3_miss", fil, 4'hF);
      tick();
    end

    // back-to-back requests; key_code changed mid-press
    col = 4'b1011; key_code = 4'h6; press_valid = 1'b1;
    n0 = xfer_q.size();
    for (int i = 0; i < 3 * TOT && xfer_q.size() < n0 + 2; i++) begin
      if (i == 15) key_code = 4'h0;
      @(negedge clk);
      if (i == 15) check("t4_code_latched", fil, 4'b1101);
      tick();
    end
    press_valid = 1'b0;
    check("t4_two_transfers", xfer_q.size(), n0 + 2);
    if (xfer_q.size() >= n0 + 2) check("t4_spacing", xfer_q[n0+1] - xfer_q[n0], TOT + 1);
    wait_idle("t4_idle_timeout");
    key_code = 4'h6;

    // reset pulsed during hold
    press(4'h6);
    repeat (10) tick();
    @(negedge clk);
    check("t5_pre_fil", fil, 4'b1101);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("t5_fil", fil, 4'hF);
    check("t5_busy", busy, 1'b0);
    check("t5_ready", press_ready, 1'b1);
    check("t5_contact", contact, 1'b0);
    tick();
    rst = 1'b1;
    tick();

    // contact toggles during bounce-in from the seed
    press(4'h6);
    tog = 0; prev = 1'b0;
    for (int i = 0; i < BNC; i++) begin
      @(negedge clk);
      if (i > 0 && contact != prev) tog++;
      prev = contact;
      tick();
    end
    check("t6_bnc_in_toggles", tog, BOUNCE_EN ? 1 : 0);
    wait_idle("t6_idle_timeout");

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
